heartbeat_framed: RTL and testbench

Parametrised Manchester beacon: transmits a framed, free-running frame counter on one output pin so a logic analyser or scope can confirm the tile is clocked and alive. Each frame carries a fixed preamble, a counter snapshot (MSB first) and an optional even-parity bit, followed by a quiet gap. Width, preamble, parity, gap length and bit rate are parameters. An enable input gates transmission. Sits directly between the tile clock and a single output pad, like the existing heartbeat cells.

---
 rtl/heartbeat_framed.sv | 171 +++++++++++++++++
 tb/tb_heartbeat_framed.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_framed.sv
// heartbeat_framed: Manchester-encoded liveness beacon.
// Every frame carries a fixed preamble, a snapshot of a free-running frame
// counter (MSB first) and an optional even-parity bit, followed by a quiet gap.
// All outputs are registered. The output for each cycle is decoded from the
// position the sequencer is about to enter.
module heartbeat_framed #(
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned PREAMBLE_W = 8,
    parameter logic [31:0] PREAMBLE   = 32'h0000_00D5,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned IDLE_BITS  = 4,
    parameter int unsigned HALF_DIV   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    output logic               signal,
    output logic               frame_start,
    output logic               busy,
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned MAXB = (PREAMBLE_W > COUNT_W)
                                 ? ((PREAMBLE_W > IDLE_BITS) ? PREAMBLE_W : IDLE_BITS)
                                 : ((COUNT_W > IDLE_BITS) ? COUNT_W : IDLE_BITS);
    localparam int unsigned BW = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int unsigned DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [PREAMBLE_W-1:0] PRE_PAT  = PREAMBLE[PREAMBLE_W-1:0];
    localparam logic [DW-1:0]         DIV_LAST = DW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  half_q, half_d;
    logic [DW-1:0]         div_q, div_d;
    logic [PREAMBLE_W-1:0] pre_q, pre_d;
    logic [COUNT_W-1:0]    pay_q, pay_d;
    logic                  par_q, par_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  signal_q, signal_d;
    logic                  frame_start_q, frame_start_d;
    logic                  busy_q, busy_d;
    logic [BW-1:0]         last_bit;
    logic                  start_frame;

    // Next position in the frame, shift-register updates and output decode.
    // Preamble and payload shift left at each bit boundary, so the MSB of the
    // next-state register is always the bit being entered.
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        half_d        = half_q;
        div_d         = div_q;
        pre_d         = pre_q;
        pay_d         = pay_q;
        par_d         = par_q;
        count_d       = count_q;
        frame_start_d = 1'b0;
        start_frame   = 1'b0;
        signal_d      = 1'b0;

        case (state_q)
            S_PRE:   last_bit = BW'(PREAMBLE_W - 1);
            S_DATA:  last_bit = BW'(COUNT_W - 1);
            S_GAP:   last_bit = BW'(IDLE_BITS - 1);
            default: last_bit = '0;
        endcase

        if (state_q == S_IDLE) begin
            start_frame = ena;
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + DW'(1);
        end else begin
            div_d = '0;
            if (!half_q) begin
                half_d = 1'b1;
            end else begin
                half_d = 1'b0;
                if (bit_q != last_bit) begin
                    bit_d = bit_q + BW'(1);
                    if (state_q == S_PRE)  pre_d = pre_q << 1;
                    if (state_q == S_DATA) pay_d = pay_q << 1;
                end else begin
                    bit_d = '0;
                    case (state_q)
                        S_PRE:  state_d = S_DATA;
                        S_DATA: begin
                            if (PARITY_EN != 0) begin
                                state_d = S_PAR;
                            end else begin
                                state_d = S_GAP;
                                count_d = count_q + COUNT_W'(1);
                            end
                        end
                        S_PAR: begin
                            state_d = S_GAP;
                            count_d = count_q + COUNT_W'(1);
                        end
                        S_GAP: begin
                            if (ena) start_frame = 1'b1;
                            else     state_d     = S_IDLE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end

        if (start_frame) begin
            state_d       = S_PRE;
            bit_d         = '0;
            half_d        = 1'b0;
            div_d         = '0;
            pre_d         = PRE_PAT;
            pay_d         = count_q;
            par_d         = ^count_q;
            frame_start_d = 1'b1;
        end

        case (state_d)
            S_PRE:   signal_d = pre_d[PREAMBLE_W-1] ^ half_d;
            S_DATA:  signal_d = pay_d[COUNT_W-1] ^ half_d;
            S_PAR:   signal_d = par_d ^ half_d;
            default: signal_d = 1'b0;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_q         <= '0;
            half_q        <= 1'b0;
            div_q         <= '0;
            pre_q         <= '0;
            pay_q         <= '0;
            par_q         <= 1'b0;
            count_q       <= '0;
            signal_q      <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            half_q        <= half_d;
            div_q         <= div_d;
            pre_q         <= pre_d;
            pay_q         <= pay_d;
            par_q         <= par_d;
            count_q       <= count_d;
            signal_q      <= signal_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign signal      = signal_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign count       = count_q;

endmodule

// File: tb/tb_heartbeat_framed.sv
// Bench for heartbeat_framed: two configurations driven by the same ena/rst,
// each compared every cycle against a frame-position model.
module tb_heartbeat_framed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;

    logic       sig_a, fs_a, busy_a;
    logic [7:0] cnt_a;
    logic       sig_b, fs_b, busy_b;
    logic [3:0] cnt_b;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    always #5 clk = ~clk;

    heartbeat_framed #(
        .COUNT_W(8), .PREAMBLE_W(8), .PREAMBLE(32'h0000_00D5),
        .PARITY_EN(1), .IDLE_BITS(4), .HALF_DIV(1)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena),
        .signal(sig_a), .frame_start(fs_a), .busy(busy_a), .count(cnt_a)
    );

    heartbeat_framed #(
        .COUNT_W(4), .PREAMBLE_W(8), .PREAMBLE(32'h0000_00D5),
        .PARITY_EN(0), .IDLE_BITS(1), .HALF_DIV(3)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena),
        .signal(sig_b), .frame_start(fs_b), .busy(busy_b), .count(cnt_b)
    );

    // Configuration table: index 0 = dut_a, 1 = dut_b.
    localparam int unsigned CW [2] = '{8, 4};
    localparam int unsigned PW [2] = '{8, 8};
    localparam int unsigned PE [2] = '{1, 0};
    localparam int unsigned IB [2] = '{4, 1};
    localparam int unsigned HD [2] = '{1, 3};
    localparam int unsigned PAT    = 32'hD5;

    // Model: k = 0 when idle, otherwise 1-based cycle index within frame+gap.
    int unsigned m_k    [2];
    int unsigned m_snap [2];
    int unsigned m_cnt  [2];

    function automatic int unsigned frame_len(int i);
        return 2 * HD[i] * (PW[i] + CW[i] + PE[i]);
    endfunction

    function automatic int unsigned period(int i);
        return 2 * HD[i] * (PW[i] + CW[i] + PE[i] + IB[i]);
    endfunction

    function automatic logic exp_sig(int i);
        int unsigned b, h, v;
        if (m_k[i] == 0 || m_k[i] > frame_len(i)) return 1'b0;
        b = (m_k[i] - 1) / (2 * HD[i]);
        h = ((m_k[i] - 1) / HD[i]) % 2;
        if (b < PW[i])
            v = (PAT >> (PW[i] - 1 - b)) & 1;
        else if (b < PW[i] + CW[i])
            v = (m_snap[i] >> (CW[i] - 1 - (b - PW[i]))) & 1;
        else
            v = $countones(m_snap[i]) % 2;
        return logic'(v ^ h);
    endfunction

    task automatic model_update(int i, logic r, logic e);
        if (r) begin
            m_k[i] = 0; m_cnt[i] = 0; m_snap[i] = 0;
        end else if (m_k[i] == 0 || m_k[i] == period(i)) begin
            if (e) begin
                m_k[i] = 1; m_snap[i] = m_cnt[i];
            end else begin
                m_k[i] = 0;
            end
        end else begin
            m_k[i] = m_k[i] + 1;
            if (m_k[i] == frame_len(i) + 1)
                m_cnt[i] = (m_cnt[i] + 1) % (1 << CW[i]);
        end
    endtask

    task automatic check_one(int i, logic s, logic f, logic b, int unsigned c);
        logic es, ef, eb;
        es = exp_sig(i);
        ef = (m_k[i] == 1);
        eb = (m_k[i] != 0);
        checks += 4;
        assert (s === es) else begin
            errors++;
            $error("FAIL signal[%0d] cyc=%0d got=%b exp=%b", i, cyc, s, es);
        end
        assert (f === ef) else begin
            errors++;
            $error("FAIL frame_start[%0d] cyc=%0d got=%b exp=%b", i, cyc, f, ef);
        end
        assert (b === eb) else begin
            errors++;
            $error("FAIL busy[%0d] cyc=%0d got=%b exp=%b", i, cyc, b, eb);
        end
        assert (c === m_cnt[i]) else begin
            errors++;
            $error("FAIL count[%0d] cyc=%0d got=%0h exp=%0h", i, cyc, c, m_cnt[i]);
        end
    endtask

    // One clock: sample the applied inputs, advance the model, compare after the edge.
    task automatic step();
        logic r, e;
        r = rst;
        e = ena;
        @(posedge clk);
        #1;
        cyc++;
        model_update(0, r, e);
        model_update(1, r, e);
        check_one(0, sig_a, fs_a, busy_a, {24'b0, cnt_a});
        check_one(1, sig_b, fs_b, busy_b, {28'b0, cnt_b});
    endtask

    task automatic expect_bit(string tag, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    logic [15:0] pre_wave;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_snap[i] = 0; m_cnt[i] = 0;
        end
        pre_wave = 16'b1010_0110_0110_0110;

        // Reset.
        rst = 1'b1; ena = 1'b0;
        repeat (3) step();

        // First frame from reset: cycle 0 is the IDLE cycle sampling ena=1.
        rst = 1'b0; ena = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 16; c++) begin
            step();
            expect_bit("preamble_wave", sig_a, pre_wave[16 - c]);
        end
        while (cyc < 43) step();
        expect_bit("fs_43", fs_a, 1'b1);
        while (cyc < 85) step();
        expect_bit("fs_85", fs_a, 1'b1);

        // ena held until the 8-bit counter wraps in dut_a (and dut_b wraps many times).
        while (cyc < 260 * 42) step();
        expect_bit("wrapped_past_ff", (cnt_a < 8'd10) ? 1'b1 : 1'b0, 1'b1);

        // Reset, then ena dropped at cycle 10 of a fresh frame.
        rst = 1'b1; step();
        rst = 1'b0; ena = 1'b1;
        cyc = 0;
        while (cyc < 10) step();
        ena = 1'b0;
        while (cyc < 43) step();
        expect_bit("busy_low_43", busy_a, 1'b0);
        expect_bit("no_fs_43", fs_a, 1'b0);
        repeat (5) step();

        // Reset mid-frame at cycle 20, then restart.
        ena = 1'b1;
        cyc = 0;
        while (cyc < 20) step();
        rst = 1'b1; step();
        expect_bit("rst_busy", busy_a, 1'b0);
        rst = 1'b0;
        repeat (100) step();

        // Randomised ena with occasional resets.
        for (int n = 0; n < 6000; n++) begin
            ena = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0; ena = 1'b0;
        repeat (200) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
